mem_access_ctrl: RTL

//  Initiator for the 256x8 single-port-style memory (valid/wr_en write port, ready/rd_en read port).

---
 rtl/mem_access_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: burst initiator for a 256x8 memory with separate write
// (mem_valid/mem_wr_en) and read (mem_ready/mem_rd_en) qualifiers.
// Host commands carry a start address and a beat count. Write beats stream in
// on wdata, and read beats stream out on rsp_*.
// Optional build macro: MEM_CTRL_VERIFY_EN enables a read-back check after
// each write beat. When it is set, mismatches set the sticky verify_err.
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  mem_valid,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_ready,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy,
  output logic                  verify_err
);

  typedef enum logic [2:0] {
    IDLE, WR, RD_ISSUE, RD_WAIT, RD_RSP, WR_VFY, VFY_WAIT
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH:0]    BEATS_ONE = {{LEN_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH:0]    beats_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  last_beat;
  logic                  wr_beat;
  logic                  rd_done;

  assign last_beat = (beats_q == BEATS_ONE);
  // Reset gates every strobe so an aborted burst never touches memory again.
  assign wr_beat   = (state_q == WR) && wdata_valid && !rst;
  assign rd_done   = (state_q == RD_RSP) && rsp_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (cmd_valid) state_d = cmd_wr ? WR : RD_ISSUE;
`ifdef MEM_CTRL_VERIFY_EN
      WR:       if (wdata_valid) state_d = WR_VFY;
      WR_VFY:   state_d = VFY_WAIT;
      VFY_WAIT: state_d = (beats_q == '0) ? IDLE : WR;
`else
      WR:       if (wdata_valid && last_beat) state_d = IDLE;
`endif
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  state_d = RD_RSP;
      RD_RSP:   if (rsp_ready) state_d = last_beat ? IDLE : RD_ISSUE;
      default:  state_d = IDLE;
    endcase
  end

  // Burst address/beat counters, read capture, and held strobe addresses/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      beats_q    <= '0;
      rsp_data_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
    end else begin
      if (state_q == IDLE && cmd_valid) begin
        addr_q  <= cmd_addr;
        beats_q <= {1'b0, cmd_len} + BEATS_ONE;
      end
      if (wr_beat || rd_done) begin
        addr_q  <= addr_q + ADDR_ONE;
        beats_q <= beats_q - BEATS_ONE;
      end
      if (wr_beat) begin
        wr_addr_q <= addr_q;
        wr_data_q <= wdata;
      end
      if (state_q == RD_ISSUE) rd_addr_q <= addr_q;
`ifdef MEM_CTRL_VERIFY_EN
      if (state_q == WR_VFY) rd_addr_q <= wr_addr_q;
`endif
      if (state_q == RD_WAIT) rsp_data_q <= mem_rd_data;
    end
  end

`ifdef MEM_CTRL_VERIFY_EN
  logic verify_err_q;

  // Sticky read-back mismatch; the written beat is still held in wr_data_q.
  always_ff @(posedge clk) begin
    if (rst) verify_err_q <= 1'b0;
    else if (state_q == VFY_WAIT && mem_rd_data != wr_data_q) verify_err_q <= 1'b1;
  end

  assign verify_err = verify_err_q;
`else
  assign verify_err = 1'b0;
`endif

  // Handshake and memory strobe outputs decoded from the current state.
  always_comb begin
    cmd_ready   = (state_q == IDLE);
    busy        = (state_q != IDLE);
    wdata_ready = 1'b0;
    rsp_valid   = 1'b0;
    rsp_last    = 1'b0;
    rsp_data    = rsp_data_q;
    mem_valid   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = wr_addr_q;
    mem_wr_data = wr_data_q;
    mem_ready   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = rd_addr_q;
    case (state_q)
      WR: begin
        wdata_ready = !rst;
        if (wr_beat) begin
          mem_valid   = 1'b1;
          mem_wr_en   = 1'b1;
          mem_wr_addr = addr_q;
          mem_wr_data = wdata;
        end
      end
      RD_ISSUE: begin
        mem_ready   = !rst;
        mem_rd_en   = !rst;
        mem_rd_addr = addr_q;
      end
      RD_RSP: begin
        rsp_valid = 1'b1;
        rsp_last  = last_beat;
      end
`ifdef MEM_CTRL_VERIFY_EN
      WR_VFY: begin
        mem_ready   = !rst;
        mem_rd_en   = !rst;
        mem_rd_addr = wr_addr_q;
      end
`endif
      default: ;
    endcase
  end

endmodule
